// File: rtl/reply_frame_gen_if.sv
// rtl/reply_frame_gen_if.sv - command receive and frame transmit handshake bundle
interface reply_frame_gen_if;
    logic        command_rx_ready;
    logic [7:0]  command_rx;
    logic [31:0] data_field_rx;
    logic        command_tx_ready;
    logic [7:0]  command_tx;
    logic [31:0] data_field_tx;
    logic        command_tx_status;
    logic        command_tx_over;

    // master is the frame generator, slave is the receiver/transmitter side
    modport master (
        input  command_rx_ready, command_rx, data_field_rx,
        input  command_tx_status, command_tx_over,
        output command_tx_ready, command_tx, data_field_tx
    );

    modport slave (
        output command_rx_ready, command_rx, data_field_rx,
        output command_tx_status, command_tx_over,
        input  command_tx_ready, command_tx, data_field_tx
    );
endinterface

// File: rtl/reply_frame_gen.sv
// rtl/reply_frame_gen.sv - reply and heartbeat frame source for the command transmitter
module reply_frame_gen #(
    parameter logic [7:0]  CMD_Q_STATUS = 8'h10,
    parameter logic [7:0]  CMD_Q_ERR    = 8'h11,
    parameter logic [7:0]  CMD_Q_VER    = 8'h12,
    parameter logic [7:0]  RSP_OFFSET   = 8'h80,
    parameter logic [7:0]  ACK_CODE     = 8'hA0,
    parameter logic [7:0]  HB_CODE      = 8'hF0,
    parameter logic [31:0] HB_PERIOD    = 32'd50_000_000,
    parameter logic [15:0] TX_TIMEOUT   = 16'd4096
) (
    input  logic              clk,
    input  logic              rst_n,
    reply_frame_gen_if.master bus,
    input  logic [31:0]       explosive_status,
    input  logic [7:0]        err_reg,
    input  logic [31:0]       version,
    output logic              reply_busy,
    output logic [7:0]        drop_cnt,
    output logic              tx_timeout
);
    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_BUSY, WAIT_DONE} state_t;

    state_t      state_q, state_d;
    logic        slot_full_q, slot_full_d;
    logic [7:0]  slot_op_q, slot_op_d;
    logic [23:0] slot_data_q, slot_data_d;
    logic        hb_pending_q, hb_pending_d;
    logic [31:0] hb_cnt_q, hb_cnt_d;
    logic        cur_hb_q, cur_hb_d;
    logic [7:0]  cur_op_q, cur_op_d;
    logic [23:0] cur_data_q, cur_data_d;
    logic [7:0]  tx_op_q, tx_op_d;
    logic [31:0] tx_data_q, tx_data_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        tx_timeout_q, tx_timeout_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic        slot_take, hb_take, hb_wrap, tmo_hit;
    logic        rx_data_hi_unused;

    // Replies only ever carry the low 24 parameter bits.
    assign rx_data_hi_unused = ^bus.data_field_rx[31:24];

    assign slot_take = (state_q == IDLE) && slot_full_q;
    assign hb_take   = (state_q == IDLE) && !slot_full_q && hb_pending_q;

    // A slot consumed by IDLE this cycle is free for a simultaneous arrival.
    always_comb begin
        slot_full_d = slot_full_q;
        slot_op_d   = slot_op_q;
        slot_data_d = slot_data_q;
        drop_cnt_d  = drop_cnt_q;
        if (bus.command_rx_ready) begin
            if (!slot_full_q || slot_take) begin
                slot_full_d = 1'b1;
                slot_op_d   = bus.command_rx;
                slot_data_d = bus.data_field_rx[23:0];
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (slot_take) begin
            slot_full_d = 1'b0;
        end
    end

    always_comb begin
        hb_wrap  = 1'b0;
        hb_cnt_d = '0;
        if (HB_PERIOD != 32'd0) begin
            hb_wrap  = (hb_cnt_q == HB_PERIOD - 32'd1);
            hb_cnt_d = hb_wrap ? 32'd0 : hb_cnt_q + 32'd1;
        end
        hb_pending_d = hb_wrap || (hb_pending_q && !hb_take);
    end

    assign tmo_hit = ({1'b0, tmo_cnt_q} + 17'd1) >= {1'b0, TX_TIMEOUT};

    always_comb begin
        state_d      = state_q;
        cur_hb_d     = cur_hb_q;
        cur_op_d     = cur_op_q;
        cur_data_d   = cur_data_q;
        tx_op_d      = tx_op_q;
        tx_data_d    = tx_data_q;
        tmo_cnt_d    = tmo_cnt_q;
        tx_timeout_d = tx_timeout_q;
        unique case (state_q)
            IDLE: begin
                if (slot_full_q) begin
                    cur_hb_d   = 1'b0;
                    cur_op_d   = slot_op_q;
                    cur_data_d = slot_data_q;
                    state_d    = LOAD;
                end else if (hb_pending_q) begin
                    cur_hb_d = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (cur_hb_q) begin
                    tx_op_d   = HB_CODE;
                    tx_data_d = explosive_status;
                end else if (cur_op_q == CMD_Q_STATUS) begin
                    tx_op_d   = cur_op_q + RSP_OFFSET;
                    tx_data_d = explosive_status;
                end else if (cur_op_q == CMD_Q_ERR) begin
                    tx_op_d   = cur_op_q + RSP_OFFSET;
                    tx_data_d = {24'h0, err_reg};
                end else if (cur_op_q == CMD_Q_VER) begin
                    tx_op_d   = cur_op_q + RSP_OFFSET;
                    tx_data_d = version;
                end else begin
                    tx_op_d   = ACK_CODE;
                    tx_data_d = {cur_op_q, cur_data_q};
                end
                state_d = SEND;
            end
            SEND: begin
                tmo_cnt_d = '0;
                state_d   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
                if (bus.command_tx_status) begin
                    tmo_cnt_d = '0;
                    state_d   = WAIT_DONE;
                end else if (bus.command_tx_over) begin
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    tx_timeout_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            WAIT_DONE: begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
                if (bus.command_tx_over) begin
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    tx_timeout_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            slot_full_q  <= 1'b0;
            slot_op_q    <= '0;
            slot_data_q  <= '0;
            hb_pending_q <= 1'b0;
            hb_cnt_q     <= '0;
            cur_hb_q     <= 1'b0;
            cur_op_q     <= '0;
            cur_data_q   <= '0;
            tx_op_q      <= '0;
            tx_data_q    <= '0;
            tmo_cnt_q    <= '0;
            tx_timeout_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            slot_full_q  <= slot_full_d;
            slot_op_q    <= slot_op_d;
            slot_data_q  <= slot_data_d;
            hb_pending_q <= hb_pending_d;
            hb_cnt_q     <= hb_cnt_d;
            cur_hb_q     <= cur_hb_d;
            cur_op_q     <= cur_op_d;
            cur_data_q   <= cur_data_d;
            tx_op_q      <= tx_op_d;
            tx_data_q    <= tx_data_d;
            tmo_cnt_q    <= tmo_cnt_d;
            tx_timeout_q <= tx_timeout_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign bus.command_tx_ready = (state_q == SEND);
    assign bus.command_tx       = tx_op_q;
    assign bus.data_field_tx    = tx_data_q;
    assign reply_busy           = (state_q != IDLE);
    assign drop_cnt             = drop_cnt_q;
    assign tx_timeout           = tx_timeout_q;
endmodule

// File: tb/tb_reply_frame_gen.sv
// tb/tb_reply_frame_gen.sv - scoreboard bench for reply_frame_gen
module tb_reply_frame_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0_n, rst1_n;
    logic [31:0] st0, st1, ver0, ver1;
    logic [7:0]  err0, err1, drop0, drop1;
    logic        busy0, busy1, to0, to1;
    logic        stall0, dead1;

    reply_frame_gen_if i0();
    reply_frame_gen_if i1();

    reply_frame_gen #(.HB_PERIOD(32'd0), .TX_TIMEOUT(16'd1024)) dut0 (
        .clk(clk), .rst_n(rst0_n), .bus(i0.master),
        .explosive_status(st0), .err_reg(err0), .version(ver0),
        .reply_busy(busy0), .drop_cnt(drop0), .tx_timeout(to0)
    );

    reply_frame_gen #(.HB_PERIOD(32'd100), .TX_TIMEOUT(16'd16)) dut1 (
        .clk(clk), .rst_n(rst1_n), .bus(i1.master),
        .explosive_status(st1), .err_reg(err1), .version(ver1),
        .reply_busy(busy1), .drop_cnt(drop1), .tx_timeout(to1)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ntx0 = 0, ntx1 = 0, last_tx0 = -1, last_tx1 = -1;
    logic [39:0] q0[$];
    logic [39:0] q1[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: every frame request is matched against the next queued reply.
    always @(negedge clk) begin
        if (i0.command_tx_ready === 1'b1) begin
            ntx0++;
            last_tx0 = cyc;
            if (q0.size() == 0) begin
                tests++; fails++;
                $display("FAIL dut0 unexpected frame: got %0h expected none", {i0.command_tx, i0.data_field_tx});
            end else begin
                chk("dut0 frame", {24'h0, i0.command_tx, i0.data_field_tx}, {24'h0, q0.pop_front()});
            end
        end
        if (i1.command_tx_ready === 1'b1) begin
            ntx1++;
            last_tx1 = cyc;
            if (q1.size() == 0) begin
                tests++; fails++;
                $display("FAIL dut1 unexpected frame: got %0h expected none", {i1.command_tx, i1.data_field_tx});
            end else begin
                chk("dut1 frame", {24'h0, i1.command_tx, i1.data_field_tx}, {24'h0, q1.pop_front()});
            end
        end
    end

    // Transmitter models: status 2 cycles after the request, over pulse later.
    initial begin
        i0.command_tx_status = 1'b0;
        i0.command_tx_over   = 1'b0;
        forever begin
            @(negedge clk);
            if (i0.command_tx_ready === 1'b1) begin
                @(posedge clk); @(posedge clk); #1 i0.command_tx_status = 1'b1;
                repeat (20) @(posedge clk);
                while (stall0) @(posedge clk);
                #1 i0.command_tx_status = 1'b0; i0.command_tx_over = 1'b1;
                @(posedge clk); #1 i0.command_tx_over = 1'b0;
            end
        end
    end

    initial begin
        i1.command_tx_status = 1'b0;
        i1.command_tx_over   = 1'b0;
        forever begin
            @(negedge clk);
            if (i1.command_tx_ready === 1'b1 && !dead1) begin
                @(posedge clk); @(posedge clk); #1 i1.command_tx_status = 1'b1;
                repeat (10) @(posedge clk);
                #1 i1.command_tx_status = 1'b0; i1.command_tx_over = 1'b1;
                @(posedge clk); #1 i1.command_tx_over = 1'b0;
            end
        end
    end

    task automatic wait_until(input int target);
        while (cyc < target) begin @(posedge clk); #1; end
    endtask

    task automatic send(input int d, input logic [7:0] op, input logic [31:0] data);
        if (d == 0) begin
            i0.command_rx_ready = 1'b1; i0.command_rx = op; i0.data_field_rx = data;
        end else begin
            i1.command_rx_ready = 1'b1; i1.command_rx = op; i1.data_field_rx = data;
        end
        @(posedge clk); #1;
        i0.command_rx_ready = 1'b0;
        i1.command_rx_ready = 1'b0;
    endtask

    task automatic wait_tx(input int d, input int n, input int budget);
        int k = 0;
        while (((d == 0) ? ntx0 : ntx1) < n && k < budget) begin @(posedge clk); #1; k++; end
        chk($sformatf("dut%0d frame count", d), 64'((d == 0) ? ntx0 : ntx1), 64'(n));
    endtask

    task automatic frame0(input logic [7:0] op, input logic [31:0] data, input logic [39:0] exp);
        int n0 = ntx0;
        q0.push_back(exp);
        send(0, op, data);
        wait_tx(0, n0 + 1, 20);
        wait_until(last_tx0 + 25);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, s, t1, t2;
        rst0_n = 1'b0; rst1_n = 1'b0; stall0 = 1'b0; dead1 = 1'b1;
        i0.command_rx_ready = 1'b0; i0.command_rx = '0; i0.data_field_rx = '0;
        i1.command_rx_ready = 1'b0; i1.command_rx = '0; i1.data_field_rx = '0;
        st0 = 32'h0000_0005; err0 = 8'h00; ver0 = 32'h0;
        st1 = 32'h0000_00A5; err1 = 8'h00; ver1 = 32'hCAFE_0001;
        repeat (3) @(posedge clk); #1;
        chk("dut0 reset outputs", {i0.command_tx_ready, i0.command_tx, i0.data_field_tx, busy0, drop0, to0}, 64'h0);
        chk("dut1 reset outputs", {i1.command_tx_ready, i1.command_tx, i1.data_field_tx, busy1, drop1, to1}, 64'h0);
        rst0_n = 1'b1; rst1_n = 1'b1;
        @(posedge clk); #1;

        // dut1 timeout: dead transmitter, second command queued behind the first
        q1.push_back({8'h92, 32'hCAFE_0001});
        q1.push_back({8'hA0, 32'h2122_3344});
        n = cyc;
        send(1, 8'h12, 32'h0);
        send(1, 8'h21, 32'h1122_3344);
        wait_tx(1, 1, 20);
        chk("dut1 first latency", 64'(last_tx1), 64'(n + 3));
        s = last_tx1;
        wait_until(s + 16);
        chk("tx_timeout before limit", 64'(to1), 64'h0);
        wait_until(s + 17);
        chk("tx_timeout at limit", 64'(to1), 64'h1);
        chk("dut1 idle after timeout", 64'(busy1), 64'h0);
        wait_tx(1, 2, 30);
        chk("pending served after timeout", 64'(last_tx1), 64'(s + 19));
        wait_until(last_tx1 + 20);
        chk("tx_timeout sticky", 64'(to1), 64'h1);
        rst1_n = 1'b0;
        @(posedge clk); #1;
        chk("tx_timeout cleared by reset", 64'(to1), 64'h0);
        dead1 = 1'b0;
        rst1_n = 1'b1;

        // dut1 heartbeat period and command/wrap collision
        q1.push_back({8'hF0, 32'h0000_00A5});
        q1.push_back({8'hF0, 32'h0000_00A5});
        q1.push_back({8'h90, 32'h0000_00A5});
        q1.push_back({8'hF0, 32'h0000_00A5});
        wait_tx(1, 3, 150);
        t1 = last_tx1;
        wait_tx(1, 4, 150);
        t2 = last_tx1;
        chk("heartbeat interval", 64'(t2 - t1), 64'd100);
        wait_until(t2 + 97);
        send(1, 8'h10, 32'h0);
        wait_tx(1, 5, 20);
        chk("collision command first", 64'(last_tx1), 64'(t2 + 100));
        wait_tx(1, 6, 40);
        chk("collision heartbeat next", 64'(last_tx1), 64'(t2 + 115));
        @(posedge clk); #1;
        rst1_n = 1'b0;

        // dut0 query status with latency and busy release
        q0.push_back({8'h90, 32'h0000_0005});
        n = cyc;
        send(0, 8'h10, 32'h0);
        wait_tx(0, 1, 20);
        chk("query status latency", 64'(last_tx0), 64'(n + 3));
        wait_until(last_tx0 + 22);
        chk("busy during over", 64'(busy0), 64'h1);
        wait_until(last_tx0 + 23);
        chk("busy after over", 64'(busy0), 64'h0);

        ver0 = 32'h0102_0304; err0 = 8'h3C;
        frame0(8'h12, 32'h0, {8'h92, 32'h0102_0304});
        frame0(8'h11, 32'h0, {8'h91, 32'h0000_003C});
        frame0(8'h21, 32'hAABB_CCDD, {8'hA0, 32'h21BB_CCDD});

        // back-to-back: third of three consecutive commands is dropped
        q0.push_back({8'h92, 32'h0102_0304});
        q0.push_back({8'h91, 32'h0000_003C});
        send(0, 8'h12, 32'h0);
        send(0, 8'h11, 32'h0);
        send(0, 8'h21, 32'h0);
        chk("drop_cnt after burst", 64'(drop0), 64'd1);
        wait_tx(0, 6, 80);
        wait_until(last_tx0 + 25);

        // overflow saturation with the transmitter stalled
        stall0 = 1'b1;
        q0.push_back({8'h90, 32'h0000_0005});
        q0.push_back({8'hA0, 32'h2100_0777});
        send(0, 8'h10, 32'h0);
        wait_tx(0, 7, 20);
        send(0, 8'h21, 32'h0000_0777);
        for (int i = 0; i < 300; i++) begin
            send(0, 8'h33, 32'(i));
            if (i == 99) chk("drop_cnt after 100 overflows", 64'(drop0), 64'd101);
        end
        chk("drop_cnt saturated", 64'(drop0), 64'hFF);
        stall0 = 1'b0;
        wait_tx(0, 8, 60);
        wait_until(last_tx0 + 25);
        chk("dut0 no timeout", 64'(to0), 64'h0);

        // reset during WAIT_DONE with the slot full discards everything
        stall0 = 1'b1;
        q0.push_back({8'hA0, 32'h21AD_BEEF});
        send(0, 8'h21, 32'hDEAD_BEEF);
        wait_tx(0, 9, 20);
        wait_until(last_tx0 + 6);
        chk("busy before reset", 64'(busy0), 64'h1);
        send(0, 8'h10, 32'h0);
        rst0_n = 1'b0;
        @(posedge clk); #1;
        chk("outputs after mid-frame reset", {i0.command_tx_ready, i0.command_tx, i0.data_field_tx, busy0, drop0, to0}, 64'h0);
        rst0_n = 1'b1;
        stall0 = 1'b0;
        repeat (80) @(posedge clk);
        #1;
        chk("no reply after reset", 64'(ntx0), 64'd9);
        chk("dut0 queue drained", 64'(q0.size()), 64'd0);
        chk("dut1 queue drained", 64'(q1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
